// File: rtl/servo_pulse_gen.sv
// Servo frame timer and pulse-width setpoint stage. Commands are held in a one-entry
// buffer and applied only at the frame wrap, optionally slew-limited per frame.
module servo_pulse_gen #(
  parameter int unsigned PERIOD_CYCLES = 1_000_000,
  parameter int unsigned MIN_WIDTH     = 50_000,
  parameter int unsigned MAX_WIDTH     = 100_000,
  parameter int unsigned STEP_PER_LSB  = 196,
  parameter int unsigned RESET_WIDTH   = 75_000,
  parameter int unsigned SLEW_STEP     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pos_valid,
  input  logic [7:0]  pos_data,
  output logic        pos_ready,
  output logic [19:0] count,
  output logic [19:0] width,
  output logic        period_start,
  output logic        ramping
);

  // Handshake: a command transfers on any edge where pos_valid and pos_ready are both high.
  // pos_ready stays low from the transfer until the wrap edge that consumes the command.

  localparam logic [19:0] LAST_COUNT = 20'(PERIOD_CYCLES - 1);
  localparam logic [19:0] MAX_W      = 20'(MAX_WIDTH);
  localparam logic [19:0] RESET_W    = 20'(RESET_WIDTH);
  localparam logic [19:0] SLEW       = 20'(SLEW_STEP);

  typedef enum logic {HOLD, RAMP} state_t;

  state_t      state, state_nx;
  logic [19:0] goal;
  logic [19:0] pend_tgt;
  logic        pending;

  logic        wrap;
  logic        accept;
  logic [31:0] tgt_full;
  logic [19:0] tgt;
  logic [19:0] next_goal;
  logic [19:0] diff;
  logic        below;
  logic [19:0] width_nx;

  assign wrap   = (count == LAST_COUNT);
  assign accept = pos_valid & pos_ready;

  // Wide product so the saturation compare sees the true value.
  assign tgt_full = 32'(MIN_WIDTH) + 32'(pos_data) * 32'(STEP_PER_LSB);
  assign tgt      = (tgt_full > 32'(MAX_WIDTH)) ? MAX_W : tgt_full[19:0];

  assign next_goal = pending ? pend_tgt : goal;
  assign below     = (width < next_goal);
  assign diff      = below ? (next_goal - width) : (width - next_goal);

  always_comb begin
    width_nx = next_goal;
    if ((SLEW != 20'd0) && (diff > SLEW))
      width_nx = below ? (width + SLEW) : (width - SLEW);
  end

  always_comb begin
    state_nx = state;
    if (wrap)
      state_nx = (width_nx != next_goal) ? RAMP : HOLD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= HOLD;
    else
      state <= state_nx;
  end

  assign ramping = (state == RAMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= 20'd0;
      period_start <= 1'b0;
    end else begin
      count        <= wrap ? 20'd0 : count + 20'd1;
      period_start <= wrap;
    end
  end

  // A transfer on the wrap edge itself is buffered, not consumed at that wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width     <= RESET_W;
      goal      <= RESET_W;
      pend_tgt  <= 20'd0;
      pending   <= 1'b0;
      pos_ready <= 1'b1;
    end else begin
      if (wrap) begin
        goal  <= next_goal;
        width <= width_nx;
      end
      if (accept) begin
        pend_tgt  <= tgt;
        pending   <= 1'b1;
        pos_ready <= 1'b0;
      end else if (wrap) begin
        pending   <= 1'b0;
        pos_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_servo_pulse_gen.sv
// Directed bench for servo_pulse_gen with a short frame: one instance jumps straight to the
// goal, the other is slew-limited to 1000 cycles of width per frame.
module tb_servo_pulse_gen;

  localparam int PER = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [7:0]  d0 = 8'd0, d1 = 8'd0;
  logic        rdy0, rdy1, ps0, ps1, rmp0, rmp1;
  logic [19:0] cnt0, cnt1, w0, w1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  servo_pulse_gen #(.PERIOD_CYCLES(PER), .SLEW_STEP(0)) dut0 (
    .clk(clk), .rst(rst), .pos_valid(v0), .pos_data(d0), .pos_ready(rdy0),
    .count(cnt0), .width(w0), .period_start(ps0), .ramping(rmp0)
  );

  servo_pulse_gen #(.PERIOD_CYCLES(PER), .SLEW_STEP(1000)) dut1 (
    .clk(clk), .rst(rst), .pos_valid(v1), .pos_data(d1), .pos_ready(rdy1),
    .count(cnt1), .width(w1), .period_start(ps1), .ramping(rmp1)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves both counters at 0, released 1 time unit after an edge.
  task automatic do_reset();
    rst = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int exp_cnt;
    rst = 1'b1;
    step(3);
    total_cnt++; if (cnt0 !== 20'd0) $display("FAIL reset_count got %0d want 0", cnt0); else pass_cnt++;
    total_cnt++; if (w0 !== 20'd75000) $display("FAIL reset_width got %0d want 75000", w0); else pass_cnt++;
    total_cnt++; if (rdy0 !== 1'b1) $display("FAIL reset_ready got %b want 1", rdy0); else pass_cnt++;
    total_cnt++; if (ps0 !== 1'b0) $display("FAIL reset_period_start got %b want 0", ps0); else pass_cnt++;
    total_cnt++; if (rmp0 !== 1'b0) $display("FAIL reset_ramping got %b want 0", rmp0); else pass_cnt++;
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 2 * PER + 5; i++) begin
      step(1);
      exp_cnt = (exp_cnt + 1) % PER;
      total_cnt++;
      if (cnt0 !== 20'(exp_cnt)) $display("FAIL count_seq got %0d want %0d", cnt0, exp_cnt); else pass_cnt++;
      total_cnt++;
      if (ps0 !== (exp_cnt == 0)) $display("FAIL period_start at count %0d got %b want %b", exp_cnt, ps0, exp_cnt == 0);
      else pass_cnt++;
    end
    total_cnt++; if (w0 !== 20'd75000) $display("FAIL idle_width got %0d want 75000", w0); else pass_cnt++;
    total_cnt++; if (rdy0 !== 1'b1) $display("FAIL idle_ready got %b want 1", rdy0); else pass_cnt++;
  endtask

  task automatic test_jump();
    do_reset();
    step(40);
    v0 = 1'b1; d0 = 8'd255;
    step(1);
    v0 = 1'b0;
    total_cnt++; if (rdy0 !== 1'b0) $display("FAIL jump_ready_drop got %b want 0", rdy0); else pass_cnt++;
    step(58);
    total_cnt++; if (cnt0 !== 20'd99) $display("FAIL jump_pre_wrap_count got %0d want 99", cnt0); else pass_cnt++;
    total_cnt++; if (w0 !== 20'd75000) $display("FAIL jump_pre_wrap_width got %0d want 75000", w0); else pass_cnt++;
    step(1);
    total_cnt++; if (cnt0 !== 20'd0) $display("FAIL jump_wrap_count got %0d want 0", cnt0); else pass_cnt++;
    total_cnt++; if (w0 !== 20'd99980) $display("FAIL jump_width got %0d want 99980", w0); else pass_cnt++;
    total_cnt++; if (rdy0 !== 1'b1) $display("FAIL jump_ready_back got %b want 1", rdy0); else pass_cnt++;
    total_cnt++; if (rmp0 !== 1'b0) $display("FAIL jump_ramping got %b want 0", rmp0); else pass_cnt++;
  endtask

  task automatic test_slew();
    int exp_w;
    do_reset();
    step(10);
    v1 = 1'b1; d1 = 8'd0;
    step(1);
    v1 = 1'b0;
    step(PER - 11);
    for (int k = 1; k <= 25; k++) begin
      exp_w = 75000 - 1000 * k;
      total_cnt++; if (w1 !== 20'(exp_w)) $display("FAIL slew_width wrap %0d got %0d want %0d", k, w1, exp_w); else pass_cnt++;
      total_cnt++; if (rmp1 !== (k < 25)) $display("FAIL slew_ramping wrap %0d got %b want %b", k, rmp1, k < 25); else pass_cnt++;
      step(PER / 2);
      total_cnt++; if (w1 !== 20'(exp_w)) $display("FAIL slew_midframe wrap %0d got %0d want %0d", k, w1, exp_w); else pass_cnt++;
      step(PER / 2);
    end
    total_cnt++; if (w1 !== 20'd50000) $display("FAIL slew_settled_width got %0d want 50000", w1); else pass_cnt++;
    total_cnt++; if (rmp1 !== 1'b0) $display("FAIL slew_settled_ramping got %b want 0", rmp1); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(10);
    v0 = 1'b1; d0 = 8'd10;
    step(1);
    d0 = 8'd200;
    step(PER - 12);
    total_cnt++; if (rdy0 !== 1'b0) $display("FAIL b2b_held_off got %b want 0", rdy0); else pass_cnt++;
    total_cnt++; if (w0 !== 20'd75000) $display("FAIL b2b_pre_wrap_width got %0d want 75000", w0); else pass_cnt++;
    step(1);
    total_cnt++; if (w0 !== 20'd51960) $display("FAIL b2b_first_width got %0d want 51960", w0); else pass_cnt++;
    total_cnt++; if (rdy0 !== 1'b1) $display("FAIL b2b_ready_reopen got %b want 1", rdy0); else pass_cnt++;
    step(1);
    v0 = 1'b0;
    total_cnt++; if (rdy0 !== 1'b0) $display("FAIL b2b_second_accept got %b want 0", rdy0); else pass_cnt++;
    step(PER - 2);
    total_cnt++; if (w0 !== 20'd51960) $display("FAIL b2b_hold_width got %0d want 51960", w0); else pass_cnt++;
    step(1);
    total_cnt++; if (w0 !== 20'd89200) $display("FAIL b2b_second_width got %0d want 89200", w0); else pass_cnt++;
    total_cnt++; if (rdy0 !== 1'b1) $display("FAIL b2b_final_ready got %b want 1", rdy0); else pass_cnt++;
  endtask

  task automatic test_wrap_accept();
    do_reset();
    step(PER - 1);
    v0 = 1'b1; d0 = 8'd128;
    step(1);
    v0 = 1'b0;
    total_cnt++; if (cnt0 !== 20'd0) $display("FAIL wacc_count got %0d want 0", cnt0); else pass_cnt++;
    total_cnt++; if (w0 !== 20'd75000) $display("FAIL wacc_not_used got %0d want 75000", w0); else pass_cnt++;
    total_cnt++; if (rdy0 !== 1'b0) $display("FAIL wacc_ready got %b want 0", rdy0); else pass_cnt++;
    step(PER - 1);
    total_cnt++; if (w0 !== 20'd75000) $display("FAIL wacc_hold got %0d want 75000", w0); else pass_cnt++;
    step(1);
    total_cnt++; if (w0 !== 20'd75088) $display("FAIL wacc_applied got %0d want 75088", w0); else pass_cnt++;
    total_cnt++; if (rdy0 !== 1'b1) $display("FAIL wacc_ready_back got %b want 1", rdy0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    step(10);
    v1 = 1'b1; d1 = 8'd255;
    step(1);
    v1 = 1'b0;
    step(PER - 11);
    total_cnt++; if (w1 !== 20'd76000) $display("FAIL rmr_first_step got %0d want 76000", w1); else pass_cnt++;
    total_cnt++; if (rmp1 !== 1'b1) $display("FAIL rmr_ramping got %b want 1", rmp1); else pass_cnt++;
    step(10);
    v1 = 1'b1; d1 = 8'd0;
    step(1);
    v1 = 1'b0;
    total_cnt++; if (rdy1 !== 1'b0) $display("FAIL rmr_pending got %b want 0", rdy1); else pass_cnt++;
    step(20);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (cnt1 !== 20'd0) $display("FAIL rmr_async_count got %0d want 0", cnt1); else pass_cnt++;
    total_cnt++; if (w1 !== 20'd75000) $display("FAIL rmr_async_width got %0d want 75000", w1); else pass_cnt++;
    total_cnt++; if (rdy1 !== 1'b1) $display("FAIL rmr_async_ready got %b want 1", rdy1); else pass_cnt++;
    total_cnt++; if (rmp1 !== 1'b0) $display("FAIL rmr_async_ramping got %b want 0", rmp1); else pass_cnt++;
    step(2);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(PER);
      total_cnt++; if (w1 !== 20'd75000) $display("FAIL rmr_discarded wrap %0d got %0d want 75000", k, w1); else pass_cnt++;
      total_cnt++; if (rmp1 !== 1'b0) $display("FAIL rmr_idle wrap %0d got %b want 0", k, rmp1); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_slew();
    test_back_to_back();
    test_wrap_accept();
    test_reset_mid_ramp();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
